// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register: latches EX results, applies stall/flush, keeps NZCV flags,
// flags illegal load+store controls and counts retired instructions.
module ex_mem_stage_reg #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             wb_en_in,
  input  logic             mem_r_en_in,
  input  logic             mem_w_en_in,
  input  logic             s_in,
  input  logic [31:0]      alu_result_in,
  input  logic [3:0]       alu_status_in,
  input  logic [31:0]      val_rm_in,
  input  logic [3:0]       dest_in,
  output logic             valid_out,
  output logic             wb_en,
  output logic             mem_r_en,
  output logic             mem_w_en,
  output logic [31:0]      alu_result,
  output logic [31:0]      val_rm,
  output logic [3:0]       dest,
  output logic [3:0]       status_reg,
  output logic             carry_out,
  output logic             ctrl_err,
  output logic [CNT_W-1:0] retired_cnt
);

  logic             valid_reg, valid_next;
  logic             wb_en_reg, wb_en_next;
  logic             mem_r_en_reg, mem_r_en_next;
  logic             mem_w_en_reg, mem_w_en_next;
  logic [31:0]      alu_result_reg, alu_result_next;
  logic [31:0]      val_rm_reg, val_rm_next;
  logic [3:0]       dest_reg, dest_next;
  logic [3:0]       status_reg_q, status_next;
  logic             ctrl_err_reg, ctrl_err_next;
  logic [CNT_W-1:0] retired_cnt_reg, retired_cnt_next;
  logic             illegal_ctrl;

  // Load and store together is undefined: retire it as a harmless no-op and flag it.
  assign illegal_ctrl = in_valid & mem_r_en_in & mem_w_en_in;

  always_comb begin
    valid_next       = valid_reg;
    wb_en_next       = wb_en_reg;
    mem_r_en_next    = mem_r_en_reg;
    mem_w_en_next    = mem_w_en_reg;
    alu_result_next  = alu_result_reg;
    val_rm_next      = val_rm_reg;
    dest_next        = dest_reg;
    status_next      = status_reg_q;
    ctrl_err_next    = ctrl_err_reg;
    retired_cnt_next = retired_cnt_reg;
    if (flush) begin
      valid_next      = 1'b0;
      wb_en_next      = 1'b0;
      mem_r_en_next   = 1'b0;
      mem_w_en_next   = 1'b0;
      alu_result_next = '0;
      val_rm_next     = '0;
      dest_next       = '0;
    end else if (!freeze) begin
      valid_next      = in_valid;
      wb_en_next      = in_valid & wb_en_in & ~illegal_ctrl;
      mem_r_en_next   = in_valid & mem_r_en_in & ~illegal_ctrl;
      mem_w_en_next   = in_valid & mem_w_en_in & ~illegal_ctrl;
      alu_result_next = alu_result_in;
      val_rm_next     = val_rm_in;
      dest_next       = dest_in;
      if (in_valid && s_in) status_next = alu_status_in;
      if (illegal_ctrl) ctrl_err_next = 1'b1;
      if (in_valid) retired_cnt_next = retired_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg       <= 1'b0;
      wb_en_reg       <= 1'b0;
      mem_r_en_reg    <= 1'b0;
      mem_w_en_reg    <= 1'b0;
      alu_result_reg  <= '0;
      val_rm_reg      <= '0;
      dest_reg        <= '0;
      status_reg_q    <= '0;
      ctrl_err_reg    <= 1'b0;
      retired_cnt_reg <= '0;
    end else begin
      valid_reg       <= valid_next;
      wb_en_reg       <= wb_en_next;
      mem_r_en_reg    <= mem_r_en_next;
      mem_w_en_reg    <= mem_w_en_next;
      alu_result_reg  <= alu_result_next;
      val_rm_reg      <= val_rm_next;
      dest_reg        <= dest_next;
      status_reg_q    <= status_next;
      ctrl_err_reg    <= ctrl_err_next;
      retired_cnt_reg <= retired_cnt_next;
    end
  end

  assign valid_out   = valid_reg;
  assign wb_en       = wb_en_reg;
  assign mem_r_en    = mem_r_en_reg;
  assign mem_w_en    = mem_w_en_reg;
  assign alu_result  = alu_result_reg;
  assign val_rm      = val_rm_reg;
  assign dest        = dest_reg;
  assign status_reg  = status_reg_q;
  // Carry feeds straight back to the ALU so a flag update is seen the next cycle.
  assign carry_out   = status_reg_q[1];
  assign ctrl_err    = ctrl_err_reg;
  assign retired_cnt = retired_cnt_reg;

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Scoreboard bench for ex_mem_stage_reg: directed vectors push expected outputs,
// a monitor pops one entry per clock and compares against the DUT.
module tb_ex_mem_stage_reg;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic             valid;
    logic             wb;
    logic             mr;
    logic             mw;
    logic [31:0]      alu;
    logic [31:0]      rm;
    logic [3:0]       dest;
    logic [3:0]       status;
    logic             carry;
    logic             err;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst, freeze, flush, in_valid, wb_en_in, mem_r_en_in, mem_w_en_in, s_in;
  logic [31:0]      alu_result_in, val_rm_in;
  logic [3:0]       alu_status_in, dest_in;
  logic             valid_out, wb_en, mem_r_en, mem_w_en, carry_out, ctrl_err;
  logic [31:0]      alu_result, val_rm;
  logic [3:0]       dest, status_reg;
  logic [CNT_W-1:0] retired_cnt;

  exp_t  exp_q[$];
  string name_q[$];
  int    tests  = 0;
  int    failed = 0;
  exp_t  m;  // expected architectural state after the most recent edge

  always #5 clk = ~clk;

  ex_mem_stage_reg #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .in_valid(in_valid),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .s_in(s_in),
    .alu_result_in(alu_result_in), .alu_status_in(alu_status_in), .val_rm_in(val_rm_in),
    .dest_in(dest_in), .valid_out(valid_out), .wb_en(wb_en), .mem_r_en(mem_r_en),
    .mem_w_en(mem_w_en), .alu_result(alu_result), .val_rm(val_rm), .dest(dest),
    .status_reg(status_reg), .carry_out(carry_out), .ctrl_err(ctrl_err),
    .retired_cnt(retired_cnt)
  );

  // Monitor: the register presents a new value every cycle.
  always @(posedge clk) begin
    exp_t  e, a;
    string n;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = '{valid_out, wb_en, mem_r_en, mem_w_en, alu_result, val_rm, dest,
            status_reg, carry_out, ctrl_err, retired_cnt};
      tests++;
      if (a !== e) begin
        failed++;
        $display("FAIL %s: got v=%b wb=%b r=%b w=%b alu=%h rm=%h d=%h st=%b c=%b err=%b cnt=%0d, want v=%b wb=%b r=%b w=%b alu=%h rm=%h d=%h st=%b c=%b err=%b cnt=%0d",
                 n, a.valid, a.wb, a.mr, a.mw, a.alu, a.rm, a.dest, a.status, a.carry, a.err, a.cnt,
                 e.valid, e.wb, e.mr, e.mw, e.alu, e.rm, e.dest, e.status, e.carry, e.err, e.cnt);
      end else begin
        $display("[TB] txn %0d %s ok: v=%b wb=%b alu=%h st=%b err=%b cnt=%0d",
                 tests, n, a.valid, a.wb, a.alu, a.status, a.err, a.cnt);
      end
    end
  end

  // Drive one edge worth of inputs and push the expected post-edge state.
  task automatic step(input string name, input bit r, input bit fl, input bit fz,
                      input bit iv, input bit w, input bit mr, input bit mw, input bit s,
                      input logic [31:0] alu, input logic [3:0] st,
                      input logic [31:0] rm, input logic [3:0] d);
    bit ill;
    @(negedge clk);
    rst = r; flush = fl; freeze = fz; in_valid = iv; wb_en_in = w;
    mem_r_en_in = mr; mem_w_en_in = mw; s_in = s;
    alu_result_in = alu; alu_status_in = st; val_rm_in = rm; dest_in = d;
    ill = iv && mr && mw;
    if (r) begin
      m = '0;
    end else if (fl) begin
      m.valid = 0; m.wb = 0; m.mr = 0; m.mw = 0; m.alu = 0; m.rm = 0; m.dest = 0;
    end else if (!fz) begin
      m.valid = iv;
      m.wb    = iv && w && !ill;
      m.mr    = iv && mr && !ill;
      m.mw    = iv && mw && !ill;
      m.alu   = alu;
      m.rm    = rm;
      m.dest  = d;
      if (iv && s) m.status = st;
      if (ill) m.err = 1'b1;
      if (iv) m.cnt = m.cnt + 1'b1;
    end
    m.carry = m.status[1];
    exp_q.push_back(m);
    name_q.push_back(name);
  endtask

  initial begin
    m = '0;
    step("reset0", 1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 4'h0);
    step("reset1", 1, 1, 1, 1, 1, 1, 0, 1, 32'hFFFF_FFFF, 4'hF, 32'h1, 4'h1);
    // Advance with flag update
    step("adv_z", 0, 0, 0, 1, 1, 0, 0, 1, 32'h0000_0000, 4'b0100, 32'h0000_1234, 4'h3);
    // No flag update
    step("no_flag", 0, 0, 0, 1, 1, 0, 0, 0, 32'hDEAD_BEEF, 4'b1010, 32'h0000_5678, 4'h5);
    // Freeze with changing inputs
    step("frz0", 0, 0, 1, 1, 0, 1, 0, 1, 32'h1111_1111, 4'b1111, 32'hAAAA_0000, 4'h7);
    step("frz1", 0, 0, 1, 0, 1, 0, 1, 1, 32'h2222_2222, 4'b0010, 32'hBBBB_0000, 4'h8);
    step("frz2", 0, 0, 1, 1, 1, 1, 1, 1, 32'h3333_3333, 4'b1001, 32'hCCCC_0000, 4'h9);
    step("flush_frz", 0, 1, 1, 1, 1, 0, 1, 1, 32'h4444_4444, 4'b1111, 32'hDDDD_0000, 4'hA);
    // Carry set, visible on carry_out
    step("carry_set", 0, 0, 0, 1, 1, 0, 0, 1, 32'h0000_0005, 4'b0010, 32'h0000_0009, 4'h2);
    step("load", 0, 0, 0, 1, 1, 1, 0, 0, 32'h0000_0100, 4'b0000, 32'h0000_0000, 4'h4);
    // Illegal load+store
    step("illegal", 0, 0, 0, 1, 1, 1, 1, 0, 32'h0000_0200, 4'b0000, 32'h0000_0077, 4'h6);
    for (int i = 0; i < 5; i++)
      step("err_sticky", 0, 0, 0, 1, (i % 2 == 0), (i == 1), (i == 3), (i == 2),
           32'h0000_1000 + i, 4'b1000, 32'h0000_2000 + i, 4'(i));
    // Bubble: controls forced low, data still loaded, not counted
    step("bubble", 0, 0, 0, 0, 1, 1, 0, 1, 32'hCAFE_F00D, 4'b0001, 32'h1357_9BDF, 4'hE);
    step("flush_err", 0, 1, 0, 1, 1, 0, 0, 1, 32'h5555_5555, 4'b0001, 32'h6666_6666, 4'hF);
    // Reset mid-stream with a flag-updating advance pending
    step("rst_mid", 1, 0, 0, 1, 1, 0, 0, 1, 32'h7777_7777, 4'b1111, 32'h8888_8888, 4'hB);
    // 17 valid advances with interleaved bubbles -> counter wraps to 1
    for (int i = 0; i < 17; i++) begin
      step("wrap_adv", 0, 0, 0, 1, 1, 0, (i == 7), 1, 32'(i * 3), 4'(i), 32'(i), 4'(i));
      if (i % 5 == 4)
        step("wrap_bub", 0, 0, 0, 0, 1, 0, 0, 1, 32'hFFFF_0000, 4'b1111, 32'h0, 4'h0);
    end
    step("rst_end", 1, 0, 0, 1, 1, 0, 0, 1, 32'h9999_9999, 4'b1111, 32'h1, 4'h1);
    step("post_rst", 0, 0, 0, 1, 0, 0, 1, 1, 32'h0000_00AB, 4'b1010, 32'h0000_00CD, 4'hC);
    @(negedge clk);
    freeze = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      tests++;
      failed++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
